// File: rtl/stream_mux_arb_pkg.sv
// Shared encodings for the packet-locked stream multiplexer and its arbiter.
package stream_mux_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after last_grant,
// wrapping from the top channel back to channel 0.
module stream_mux_arb_rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_grant,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    // Pass one covers channels above last_grant, pass two wraps to the rest.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && req[k] && (SEL_W'(k) > last_grant)) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && req[k] && (SEL_W'(k) <= last_grant)) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// NUM_CH-input valid/ready stream multiplexer with fixed-select or round-robin
// arbitration, grant held for a whole packet, and a registered output stage.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NUM_CH    = 5,
    parameter int SEL_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH-1:0]           in_last,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    output logic [WORD_SIZE-1:0]        out_data,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_ch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        err_sel
);

    localparam logic [SEL_W:0]   NUM_CH_X = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH-1);

    state_e                 r_state;
    state_e                 w_next_state;
    logic [SEL_W-1:0]       r_grant;
    logic [SEL_W-1:0]       w_next_grant;
    logic [SEL_W-1:0]       r_last_grant;
    logic [WORD_SIZE-1:0]   r_out_data;
    logic                   r_out_last;
    logic [SEL_W-1:0]       r_out_ch;
    logic                   r_out_valid;
    logic                   r_err_sel;

    logic                   w_load_en;
    logic                   w_sel_ok;
    logic                   w_sel_req;
    logic                   w_g_valid;
    logic                   w_g_last;
    logic [WORD_SIZE-1:0]   w_g_data;
    logic                   w_grant_ready;
    logic                   w_xfer;
    logic [SEL_W-1:0]       w_rr_idx;
    logic                   w_rr_vld;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_ok  = {1'b0, sel} < NUM_CH_X;

    stream_mux_arb_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req        (in_valid),
        .last_grant (r_last_grant),
        .gnt_idx    (w_rr_idx),
        .gnt_vld    (w_rr_vld)
    );

    // Channel lookups by index; out-of-range indices simply match nothing.
    always_comb begin
        w_sel_req = 1'b0;
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == sel) begin
                w_sel_req = in_valid[k];
            end
            if (SEL_W'(k) == r_grant) begin
                w_g_valid = in_valid[k];
                w_g_last  = in_last[k];
                w_g_data  = in_data[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (mode == MODE_FIXED) begin
                    if (w_sel_ok && w_sel_req) begin
                        w_next_state = ST_LOCK;
                        w_next_grant = sel;
                    end
                end else if (w_rr_vld) begin
                    w_next_state = ST_LOCK;
                    w_next_grant = w_rr_idx;
                end
            end
            ST_LOCK: begin
                if (w_xfer && w_g_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Only the locked channel may see ready, and only when the output slot frees up.
    always_comb begin
        w_grant_ready = (r_state == ST_LOCK) && w_load_en && !rst;
        w_xfer        = w_grant_ready && w_g_valid;
        in_ready      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            in_ready[k] = w_grant_ready && (SEL_W'(k) == r_grant);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= LAST_CH;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_ch     <= '0;
            r_out_valid  <= 1'b0;
            r_err_sel    <= 1'b0;
        end else begin
            r_grant   <= w_next_grant;
            r_err_sel <= (r_state == ST_IDLE) && (mode == MODE_FIXED) && !w_sel_ok;
            if (w_xfer && w_g_last) begin
                r_last_grant <= r_grant;
            end
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_g_data;
                    r_out_last <= w_g_last;
                    r_out_ch   <= r_grant;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign err_sel   = r_err_sel;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Self-checking bench for stream_mux_arb: vector table, directed corner sequences
// and a randomized round-robin run scored against a packet-level model.
module tb_stream_mux_arb;

    localparam int WORD_SIZE = 8;
    localparam int NUM_CH    = 5;
    localparam int SEL_W     = 3;
    localparam int NPKT      = 4;
    localparam int MAXLEN    = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic [NUM_CH*WORD_SIZE-1:0] in_data = '0;
    logic [NUM_CH-1:0]           in_valid = '0;
    logic [NUM_CH-1:0]           in_last = '0;
    logic [NUM_CH-1:0]           in_ready;
    logic                        mode = 1'b0;
    logic [SEL_W-1:0]            sel = '0;
    logic [WORD_SIZE-1:0]        out_data;
    logic                        out_last;
    logic [SEL_W-1:0]            out_ch;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic                        err_sel;
    logic                        rstReq = 1'b0;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [NUM_CH-1:0] valid;
        logic              expErr;
        logic [NUM_CH-1:0] expReady;
        logic              expOutValid;
        logic [SEL_W-1:0]  expCh;
    } vec_t;

    typedef struct {
        logic [SEL_W-1:0]     ch;
        logic [WORD_SIZE-1:0] data;
        logic                 last;
    } beat_t;

    vec_t  vecs[7];
    beat_t expQ[$];
    logic [WORD_SIZE-1:0] pktData[NUM_CH][NPKT][MAXLEN];
    int    pktLen[NUM_CH][NPKT];
    int    pktIdx[NUM_CH];
    int    beatIdx[NUM_CH];

    always #5 clk = ~clk;

    stream_mux_arb #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_CH    (NUM_CH),
        .SEL_W     (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic applyStimulus(input logic m, input logic [SEL_W-1:0] s, input logic [NUM_CH-1:0] v,
                                 input logic [NUM_CH-1:0] l, input logic [NUM_CH*WORD_SIZE-1:0] d,
                                 input logic ordy);
        @(posedge clk);
        #1;
        rst       = rstReq;
        mode      = m;
        sel       = s;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [NUM_CH*WORD_SIZE-1:0] chData(input int ch, input logic [WORD_SIZE-1:0] val);
        logic [NUM_CH*WORD_SIZE-1:0] b;
        b = '0;
        b[ch*WORD_SIZE +: WORD_SIZE] = val;
        return b;
    endfunction

    // Round-robin model: after each packet, the next one comes from the first channel
    // after the previous winner that still has packets queued.
    task automatic buildExpected();
        int taken[NUM_CH];
        int lastG;
        int left;
        lastG = NUM_CH - 1;
        left  = NUM_CH * NPKT;
        foreach (taken[c]) taken[c] = 0;
        while (left > 0) begin
            for (int off = 1; off <= NUM_CH; off++) begin
                int c;
                c = (lastG + off) % NUM_CH;
                if (taken[c] < NPKT) begin
                    for (int b = 0; b < pktLen[c][taken[c]]; b++) begin
                        beat_t e;
                        e.ch   = SEL_W'(c);
                        e.data = pktData[c][taken[c]][b];
                        e.last = (b == pktLen[c][taken[c]] - 1);
                        expQ.push_back(e);
                    end
                    taken[c]++;
                    lastG = c;
                    left--;
                    break;
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NUM_CH*WORD_SIZE-1:0] allData;
        logic [NUM_CH*WORD_SIZE-1:0] rrData;
        logic [NUM_CH*WORD_SIZE-1:0] d;
        logic [NUM_CH-1:0]           v;
        logic [NUM_CH-1:0]           l;
        logic                        ordy;
        bit                          done;

        vecs[0] = '{3'd0, 5'b11111, 1'b0, 5'b00001, 1'b1, 3'd0};
        vecs[1] = '{3'd2, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd2};
        vecs[2] = '{3'd3, 5'b00100, 1'b0, 5'b00000, 1'b0, 3'd0};
        vecs[3] = '{3'd4, 5'b11111, 1'b0, 5'b10000, 1'b1, 3'd4};
        vecs[4] = '{3'd5, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0};
        vecs[5] = '{3'd6, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd0};
        vecs[6] = '{3'd7, 5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};

        allData = '0;
        rrData  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            allData |= chData(c, 8'hC0 + 8'(c));
            rrData  |= chData(c, 8'(c));
        end

        doReset();
        @(negedge clk);
        checkOutput("reset out_valid", 32'(out_valid), 0);
        checkOutput("reset out_data", 32'(out_data), 0);
        checkOutput("reset out_ch", 32'(out_ch), 0);
        checkOutput("reset out_last", 32'(out_last), 0);
        checkOutput("reset err_sel", 32'(err_sel), 0);
        checkOutput("reset in_ready", 32'(in_ready), 0);

        // Fixed-select table: err flag and ready one cycle in, output beat two cycles in.
        for (int i = 0; i < 7; i++) begin
            doReset();
            applyStimulus(1'b0, vecs[i].sel, vecs[i].valid, '1, allData, 1'b1);
            applyStimulus(1'b0, vecs[i].sel, vecs[i].valid, '1, allData, 1'b1);
            checkOutput($sformatf("vec%0d err_sel", i), 32'(err_sel), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            applyStimulus(1'b0, vecs[i].sel, vecs[i].valid, '1, allData, 1'b1);
            checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].expOutValid));
            if (vecs[i].expOutValid) begin
                checkOutput($sformatf("vec%0d out_ch", i), 32'(out_ch), 32'(vecs[i].expCh));
                checkOutput($sformatf("vec%0d out_data", i), 32'(out_data), 32'(8'hC0 + 8'(vecs[i].expCh)));
            end
        end

        // Fixed sel=2, three-beat packet.
        doReset();
        applyStimulus(1'b0, 3'd2, 5'b00100, 5'b00000, chData(2, 8'h11), 1'b1);
        checkOutput("fix c0 in_ready", 32'(in_ready), 0);
        applyStimulus(1'b0, 3'd2, 5'b00100, 5'b00000, chData(2, 8'h11), 1'b1);
        checkOutput("fix c1 in_ready", 32'(in_ready), 32'h4);
        applyStimulus(1'b0, 3'd2, 5'b00100, 5'b00000, chData(2, 8'h22), 1'b1);
        checkOutput("fix c2 out_valid", 32'(out_valid), 1);
        checkOutput("fix c2 out_data", 32'(out_data), 32'h11);
        checkOutput("fix c2 out_ch", 32'(out_ch), 2);
        checkOutput("fix c2 out_last", 32'(out_last), 0);
        applyStimulus(1'b0, 3'd2, 5'b00100, 5'b00100, chData(2, 8'h33), 1'b1);
        checkOutput("fix c3 out_data", 32'(out_data), 32'h22);
        checkOutput("fix c3 out_last", 32'(out_last), 0);
        applyStimulus(1'b0, 3'd2, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("fix c4 out_data", 32'(out_data), 32'h33);
        checkOutput("fix c4 out_last", 32'(out_last), 1);
        checkOutput("fix c4 out_valid", 32'(out_valid), 1);
        applyStimulus(1'b0, 3'd2, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("fix c5 out_valid", 32'(out_valid), 0);

        // Round-robin, every channel always offering a one-beat packet.
        doReset();
        for (int n = 0; n <= 12; n++) begin
            applyStimulus(1'b1, 3'd0, 5'b11111, 5'b11111, rrData, 1'b1);
            if (n >= 2 && n % 2 == 0) begin
                checkOutput($sformatf("rr c%0d out_valid", n), 32'(out_valid), 1);
                checkOutput($sformatf("rr c%0d out_ch", n), 32'(out_ch), 32'(((n / 2) - 1) % NUM_CH));
                checkOutput($sformatf("rr c%0d out_data", n), 32'(out_data), 32'(((n / 2) - 1) % NUM_CH));
            end else if (n % 2 == 1) begin
                checkOutput($sformatf("rr c%0d out_valid", n), 32'(out_valid), 0);
                checkOutput($sformatf("rr c%0d in_ready", n), 32'(in_ready), 32'(1 << (((n - 1) / 2) % NUM_CH)));
            end
        end

        // Backpressure on ch1 while the second beat waits.
        doReset();
        applyStimulus(1'b0, 3'd1, 5'b00010, 5'b00000, chData(1, 8'hA5), 1'b1);
        applyStimulus(1'b0, 3'd1, 5'b00010, 5'b00000, chData(1, 8'hA5), 1'b1);
        checkOutput("bp c1 in_ready", 32'(in_ready), 32'h2);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 3'd1, 5'b00010, 5'b00010, chData(1, 8'h5A), 1'b0);
            checkOutput($sformatf("bp hold%0d out_data", n), 32'(out_data), 32'hA5);
            checkOutput($sformatf("bp hold%0d out_valid", n), 32'(out_valid), 1);
            checkOutput($sformatf("bp hold%0d in_ready", n), 32'(in_ready), 0);
        end
        applyStimulus(1'b0, 3'd1, 5'b00010, 5'b00010, chData(1, 8'h5A), 1'b1);
        checkOutput("bp release out_data", 32'(out_data), 32'hA5);
        checkOutput("bp release in_ready", 32'(in_ready), 32'h2);
        applyStimulus(1'b0, 3'd1, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("bp second out_data", 32'(out_data), 32'h5A);
        checkOutput("bp second out_last", 32'(out_last), 1);
        checkOutput("bp second out_valid", 32'(out_valid), 1);
        applyStimulus(1'b0, 3'd1, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("bp no dup c1", 32'(out_valid), 0);
        applyStimulus(1'b0, 3'd1, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("bp no dup c2", 32'(out_valid), 0);

        // Bad select, then recovery to ch4.
        doReset();
        d = chData(4, 8'h44);
        applyStimulus(1'b0, 3'd6, 5'b11111, 5'b11111, d, 1'b1);
        applyStimulus(1'b0, 3'd6, 5'b11111, 5'b11111, d, 1'b1);
        checkOutput("err c1 err_sel", 32'(err_sel), 1);
        checkOutput("err c1 in_ready", 32'(in_ready), 0);
        applyStimulus(1'b0, 3'd6, 5'b11111, 5'b11111, d, 1'b1);
        checkOutput("err c2 err_sel", 32'(err_sel), 1);
        checkOutput("err c2 in_ready", 32'(in_ready), 0);
        checkOutput("err c2 out_valid", 32'(out_valid), 0);
        applyStimulus(1'b0, 3'd4, 5'b11111, 5'b11111, d, 1'b1);
        checkOutput("err c3 err_sel", 32'(err_sel), 1);
        applyStimulus(1'b0, 3'd4, 5'b11111, 5'b11111, d, 1'b1);
        checkOutput("err c4 err_sel", 32'(err_sel), 0);
        checkOutput("err c4 in_ready", 32'(in_ready), 32'h10);
        applyStimulus(1'b0, 3'd4, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("err c5 out_ch", 32'(out_ch), 4);
        checkOutput("err c5 out_data", 32'(out_data), 32'h44);

        // Reset during the second beat of a ch3 packet.
        doReset();
        applyStimulus(1'b0, 3'd3, 5'b01000, 5'b00000, chData(3, 8'h30), 1'b1);
        applyStimulus(1'b0, 3'd3, 5'b01000, 5'b00000, chData(3, 8'h30), 1'b1);
        checkOutput("rstmid c1 in_ready", 32'(in_ready), 32'h8);
        rstReq = 1'b1;
        applyStimulus(1'b0, 3'd3, 5'b01000, 5'b00000, chData(3, 8'h31), 1'b1);
        rstReq = 1'b0;
        checkOutput("rstmid c2 in_ready", 32'(in_ready), 0);
        checkOutput("rstmid c2 out_data", 32'(out_data), 32'h30);
        d = chData(3, 8'h31) | chData(0, 8'h0F);
        applyStimulus(1'b1, 3'd3, 5'b01001, 5'b00001, d, 1'b1);
        checkOutput("rstmid c3 out_valid", 32'(out_valid), 0);
        applyStimulus(1'b1, 3'd3, 5'b01001, 5'b00001, d, 1'b1);
        checkOutput("rstmid c4 in_ready", 32'(in_ready), 32'h1);
        applyStimulus(1'b1, 3'd3, 5'b01001, 5'b00001, d, 1'b1);
        checkOutput("rstmid c5 out_ch", 32'(out_ch), 0);
        checkOutput("rstmid c5 out_data", 32'(out_data), 32'h0F);

        // Mode/select change while ch1 is locked.
        doReset();
        applyStimulus(1'b0, 3'd1, 5'b00011, 5'b00001, chData(1, 8'h61) | chData(0, 8'h0A), 1'b1);
        applyStimulus(1'b0, 3'd1, 5'b00011, 5'b00001, chData(1, 8'h61) | chData(0, 8'h0A), 1'b1);
        checkOutput("modechg c1 in_ready", 32'(in_ready), 32'h2);
        applyStimulus(1'b1, 3'd0, 5'b00011, 5'b00001, chData(1, 8'h62) | chData(0, 8'h0A), 1'b1);
        checkOutput("modechg c2 out_data", 32'(out_data), 32'h61);
        checkOutput("modechg c2 out_ch", 32'(out_ch), 1);
        applyStimulus(1'b1, 3'd0, 5'b00011, 5'b00011, chData(1, 8'h63) | chData(0, 8'h0A), 1'b1);
        checkOutput("modechg c3 out_data", 32'(out_data), 32'h62);
        checkOutput("modechg c3 in_ready", 32'(in_ready), 32'h2);
        applyStimulus(1'b1, 3'd0, 5'b00001, 5'b00001, chData(0, 8'h0A), 1'b1);
        checkOutput("modechg c4 out_data", 32'(out_data), 32'h63);
        checkOutput("modechg c4 out_last", 32'(out_last), 1);
        checkOutput("modechg c4 in_ready", 32'(in_ready), 0);
        applyStimulus(1'b1, 3'd0, 5'b00001, 5'b00001, chData(0, 8'h0A), 1'b1);
        checkOutput("modechg c5 in_ready", 32'(in_ready), 32'h1);
        applyStimulus(1'b1, 3'd0, 5'b00000, 5'b00000, '0, 1'b1);
        checkOutput("modechg c6 out_ch", 32'(out_ch), 0);
        checkOutput("modechg c6 out_data", 32'(out_data), 32'h0A);

        // Randomized round-robin traffic with mid-packet bubbles and output stalls.
        for (int c = 0; c < NUM_CH; c++) begin
            pktIdx[c]  = 0;
            beatIdx[c] = 0;
            for (int p = 0; p < NPKT; p++) begin
                pktLen[c][p] = $urandom_range(1, MAXLEN);
                for (int b = 0; b < MAXLEN; b++) pktData[c][p][b] = 8'($urandom);
            end
        end
        buildExpected();
        doReset();
        done = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            d = '0;
            v = '0;
            l = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (pktIdx[c] < NPKT) begin
                    v[c] = (beatIdx[c] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    l[c] = (beatIdx[c] == pktLen[c][pktIdx[c]] - 1);
                    d |= chData(c, pktData[c][pktIdx[c]][beatIdx[c]]);
                end else begin
                    d |= chData(c, 8'($urandom));
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(1'b1, 3'd0, v, l, d, ordy);
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("rand extra beat", 32'(expQ.size()), 1);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("rand out_ch", 32'(out_ch), 32'(e.ch));
                    checkOutput("rand out_data", 32'(out_data), 32'(e.data));
                    checkOutput("rand out_last", 32'(out_last), 32'(e.last));
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c] && in_ready[c]) begin
                    if (in_last[c]) begin
                        pktIdx[c]++;
                        beatIdx[c] = 0;
                    end else begin
                        beatIdx[c]++;
                    end
                end
            end
            done = (expQ.size() == 0);
        end
        checkOutput("rand beats left", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised successor of the 5-channel word mux: NUM_CH-input streaming multiplexer with valid/ready handshake on every port and a registered output.
- Two modes: fixed select (external sel) or round-robin arbitration.
- Grant is locked for a whole packet, terminated by last.
- Sits between multiple producers (ALU/datapath sources) and a single consumer bus.

Parameters:
- WORD_SIZE, 8, data width per channel.
- NUM_CH, 5, number of input channels (2..16).
- SEL_W, 3, select/channel-index width; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  NUM_CH*WORD_SIZE  packed channel data; channel k occupies bits [k*WORD_SIZE +: WORD_SIZE].
- in_valid  in  NUM_CH  per-channel beat valid.
- in_last  in  NUM_CH  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  out  NUM_CH  per-channel accept.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used when mode = 0.
- out_data  out  WORD_SIZE  registered output data.
- out_last  out  1  registered end-of-packet flag.
- out_ch  out  SEL_W  source channel of the current output beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- err_sel  out  1  registered flag: mode = 0 and sel >= NUM_CH, sampled in IDLE.

Behaviour:
- Reset (synchronous, rst = 1 at clk edge):
  - state = IDLE.
  - out_valid, out_last and err_sel = 0; out_data and out_ch = 0.
  - grant = 0; last_grant = NUM_CH-1, so the first round-robin pick is channel 0.
  - in_ready = 0 throughout reset.
- Output register advances when load_en = !out_valid || out_ready.
- FSM states: IDLE, LOCK.
- IDLE:
  - in_ready = 0.
  - mode and sel are sampled only in IDLE.
  - Mode 0: if sel < NUM_CH and in_valid[sel] = 1, set grant = sel and go to LOCK. If sel >= NUM_CH, no grant is made and err_sel = 1 next cycle; err_sel stays high while the condition persists in IDLE.
  - Mode 1: grant is the first k with in_valid[k] = 1, searching cyclically from last_grant+1 and wrapping NUM_CH-1 to 0; then go to LOCK. No valid channel means stay in IDLE.
- LOCK:
  - in_ready[grant] = load_en; all other in_ready bits = 0.
  - A beat transfers when in_valid[grant] && in_ready[grant]. On transfer, out_data, out_last and out_ch load from the channel and out_valid = 1.
  - If load_en = 1 and there is no transfer, out_valid = 0.
  - A transfer with in_last[grant] = 1 sets last_grant = grant and returns the FSM to IDLE.
  - mode/sel changes during LOCK are ignored until IDLE.
- Latency:
  - Request seen in IDLE at cycle 0, grant registered at edge 1.
  - in_ready is high in cycle 1; the beat is accepted at edge 2; out_valid = 1 in cycle 2.
  - Steady state after that: 1 beat/cycle.
  - Minimum gap between packets: one IDLE cycle.
- Backpressure:
  - out_valid = 1 and out_ready = 0 forces load_en = 0 and in_ready = 0.
  - out_data, out_last and out_ch are held stable, with no loss or duplication.
- Single-beat packet (in_last = 1 on the first beat): LOCK lasts exactly one transfer.
- Round-robin fairness: a continuously requesting channel waits at most NUM_CH-1 packets.
- Reset mid-packet:
  - Output beat is dropped, out_valid = 0, FSM returns to IDLE, last_grant = NUM_CH-1.
  - Partial packets are not resumed.
- Packed-bus slicing uses constant part-select widths only; no X-propagation outputs (unlike the 'bx default of the old mux).

Decomposition:
- Shared package/header (mux_defs.vh): mode encodings MODE_FIXED = 1'b0, MODE_RR = 1'b1; state encodings ST_IDLE, ST_LOCK.
- One natural sub-module: rr_arbiter (NUM_CH, SEL_W). It is combinational: inputs req vector and last_grant; outputs gnt_idx and gnt_vld.

Test Plan:
- Fixed mode, sel = 2, ch2 sends 3-beat packet 0x11, 0x22, 0x33 (last on 0x33), out_ready = 1 -> out_data 0x11/0x22/0x33 on consecutive cycles starting 2 cycles after request, out_ch = 2, out_last only on 0x33.
- Round-robin, all 5 channels valid with 1-beat packets carrying data = channel index -> out_ch sequence 0,1,2,3,4,0, one IDLE cycle between beats.
- Backpressure: out_ready = 0 for 3 cycles mid-packet on ch1 (0xA5 then 0x5A) -> out_data holds 0xA5, in_ready[1] = 0, 0x5A appears exactly once after release.
- Fixed mode, sel = 6 with NUM_CH = 5 -> err_sel = 1, no in_ready asserted, out_valid stays 0. Then sel = 4 -> err_sel clears and ch4 is granted.
- rst asserted during the 2nd beat of a 4-beat packet on ch3 -> next cycle out_valid = 0 and state IDLE; round-robin next pick is ch0 even with ch3 and ch0 requesting.
- mode/sel changed from 0/1 to 1/x during a ch1 packet -> packet completes from ch1 uninterrupted, new mode applies from the next IDLE.
